// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I constants for the memory-port arbiter. Holds the
//               instruction word size, load/store funct3 encodings and the
//               response-owner enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int INSTRUCTION_SIZE = 32;

  // RV32I load/store funct3 encodings (stores reuse the low three)
  localparam logic [2:0] F3_B  = 3'b000;  // lb / sb
  localparam logic [2:0] F3_H  = 3'b001;  // lh / sh
  localparam logic [2:0] F3_W  = 3'b010;  // lw / sw
  localparam logic [2:0] F3_BU = 3'b100;  // lbu
  localparam logic [2:0] F3_HU = 3'b101;  // lhu

  // Which requester owns the response slot in the current cycle
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_align_check
// Description : Flags a naturally misaligned RV32I access.
//   funct3     in  3  access size encoding
//   addr_lo    in  2  low two bits of the byte address
//   misaligned out 1  word access not on 4-byte, half access not on 2-byte
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align_check
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_W:       misaligned = (addr_lo != 2'b00);
      F3_H, F3_HU: misaligned = addr_lo[0];
      default:    misaligned = 1'b0;  // byte accesses are always aligned
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-cycle memory port between an instruction
//               fetch requester and a data load/store requester. Data wins by
//               default; fetch is forced through after STARVE_LIMIT lost
//               cycles. Responses return exactly one cycle after the grant.
//   CLK, Reset_n            clock / async active-low reset
//   IReq, IAddr             fetch request / byte address
//   IGnt, IValid, IErr      fetch grant / response valid / misaligned
//   IRdata                  fetched word
//   DReq, DWe, DFunct3      data request / store / access size
//   DAddr, DWdata           data byte address / store data
//   DGnt, DValid, DErr      data grant / response valid / misaligned
//   DRdata                  load result
//   MemEn, MemWe, MemFunct3 memory port command
//   MemAddr, MemWdata       memory port address / write data
//   MemRdata                memory read data, valid the cycle after MemEn
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = INSTRUCTION_SIZE
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IGnt,
  output logic              IValid,
  output logic              IErr,
  output logic [ADDR_W-1:0] IRdata,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [2:0]        DFunct3,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [ADDR_W-1:0] DWdata,
  output logic              DGnt,
  output logic              DValid,
  output logic              DErr,
  output logic [ADDR_W-1:0] DRdata,
  output logic              MemEn,
  output logic              MemWe,
  output logic [2:0]        MemFunct3,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [ADDR_W-1:0] MemWdata,
  input  logic [ADDR_W-1:0] MemRdata
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  resp_owner_e resp_q, resp_d;
  logic        err_q, err_d;
  logic        store_q, store_d;

  logic w_i_mis, w_d_mis;
  logic w_force_i, w_ignt, w_dgnt;

  mem_align_check u_ialign (
    .funct3     (F3_W),
    .addr_lo    (IAddr[1:0]),
    .misaligned (w_i_mis)
  );

  mem_align_check u_dalign (
    .funct3     (DFunct3),
    .addr_lo    (DAddr[1:0]),
    .misaligned (w_d_mis)
  );

  // Grants are qualified with Reset_n so every output is low while reset is
  // held, even though the requests themselves may still be asserted.
  always_comb begin
    w_force_i = IReq && (starve_cnt_q == C_STARVE_LIMIT);
    w_ignt    = Reset_n && IReq && (!DReq || w_force_i);
    w_dgnt    = Reset_n && DReq && !w_ignt;
  end

  // Memory command: misaligned requests are granted but never reach memory
  always_comb begin
    MemEn     = 1'b0;
    MemWe     = 1'b0;
    MemFunct3 = 3'b000;
    MemAddr   = '0;
    MemWdata  = '0;
    if (w_ignt && !w_i_mis) begin
      MemEn     = 1'b1;
      MemFunct3 = F3_W;
      MemAddr   = IAddr;
    end else if (w_dgnt && !w_d_mis) begin
      MemEn     = 1'b1;
      MemWe     = DWe;
      MemFunct3 = DFunct3;
      MemAddr   = DAddr;
      MemWdata  = DWe ? DWdata : '0;
    end
  end

  // Next-state: response owner, its error/store flags and the starvation count
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    resp_d       = RESP_NONE;
    err_d        = 1'b0;
    store_d      = 1'b0;
    if (w_ignt) begin
      starve_cnt_d = 4'd0;
      resp_d       = RESP_I;
      err_d        = w_i_mis;
    end else if (w_dgnt) begin
      resp_d  = RESP_D;
      err_d   = w_d_mis;
      store_d = DWe;
      if (IReq && (starve_cnt_q != C_STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_cnt_q <= 4'd0;
      resp_q       <= RESP_NONE;
      err_q        <= 1'b0;
      store_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      store_q      <= store_d;
    end
  end

  // Response side: memory data is passed through only for good reads
  always_comb begin
    IGnt   = w_ignt;
    DGnt   = w_dgnt;
    IValid = (resp_q == RESP_I);
    DValid = (resp_q == RESP_D);
    IErr   = IValid && err_q;
    DErr   = DValid && err_q;
    IRdata = (IValid && !err_q) ? MemRdata : '0;
    DRdata = (DValid && !err_q && !store_q) ? MemRdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: table vectors,
//               hand-written reset/starvation/pipelining sequences and a
//               randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int LIMIT = 4;
  localparam int AW    = 32;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IGnt, IValid, IErr;
  logic [AW-1:0] IRdata;
  logic          DReq, DWe;
  logic [2:0]    DFunct3;
  logic [AW-1:0] DAddr, DWdata;
  logic          DGnt, DValid, DErr;
  logic [AW-1:0] DRdata;
  logic          MemEn, MemWe;
  logic [2:0]    MemFunct3;
  logic [AW-1:0] MemAddr, MemWdata, MemRdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IErr(IErr), .IRdata(IRdata),
    .DReq(DReq), .DWe(DWe), .DFunct3(DFunct3), .DAddr(DAddr), .DWdata(DWdata),
    .DGnt(DGnt), .DValid(DValid), .DErr(DErr), .DRdata(DRdata),
    .MemEn(MemEn), .MemWe(MemWe), .MemFunct3(MemFunct3), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_starve;          // lost fetch cycles so far
  int m_owner;           // 0 none, 1 fetch, 2 data response due this cycle
  bit m_err, m_store;
  bit last_ignt, last_dgnt;

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    case (f3[1:0])
      2'd0:    sz = 1;
      2'd1:    sz = 2;
      default: sz = 4;
    endcase
    return (a % sz) != 0;
  endfunction

  task automatic model_reset();
    m_starve = 0; m_owner = 0; m_err = 0; m_store = 0;
    last_ignt = 0; last_dgnt = 0;
  endtask

  task automatic model_check();
    bit eig, edg, mi, md, en, we;
    logic [2:0]  f3;
    logic [31:0] ad, wd;
    eig = IReq && (!DReq || m_starve == LIMIT);
    edg = DReq && !eig;
    mi  = (IAddr % 4) != 0;
    md  = misaligned(DFunct3, DAddr);
    en = 0; we = 0; f3 = 3'b000; ad = '0; wd = '0;
    if (eig && !mi) begin
      en = 1; f3 = 3'b010; ad = IAddr;
    end else if (edg && !md) begin
      en = 1; we = DWe; f3 = DFunct3; ad = DAddr; wd = DWe ? DWdata : 32'h0;
    end
    chk("IGnt", 32'(IGnt), 32'(eig));
    chk("DGnt", 32'(DGnt), 32'(edg));
    chk("MemEn", 32'(MemEn), 32'(en));
    chk("MemWe", 32'(MemWe), 32'(we));
    chk("MemFunct3", 32'(MemFunct3), 32'(f3));
    chk("MemAddr", MemAddr, ad);
    chk("MemWdata", MemWdata, wd);
    chk("IValid", 32'(IValid), 32'(m_owner == 1));
    chk("DValid", 32'(DValid), 32'(m_owner == 2));
    chk("IErr", 32'(IErr), 32'(m_owner == 1 && m_err));
    chk("DErr", 32'(DErr), 32'(m_owner == 2 && m_err));
    chk("IRdata", IRdata, (m_owner == 1 && !m_err) ? MemRdata : 32'h0);
    chk("DRdata", DRdata, (m_owner == 2 && !m_err && !m_store) ? MemRdata : 32'h0);
    // advance to the next cycle
    m_owner = eig ? 1 : (edg ? 2 : 0);
    m_err   = eig ? mi : (edg ? md : 0);
    m_store = edg && DWe;
    if (eig) m_starve = 0;
    else if (IReq && edg && m_starve < LIMIT) m_starve++;
    last_ignt = IGnt; last_dgnt = DGnt;
  endtask

  // ---------------- cycle helpers ----------------
  task automatic sample_cycle();
    @(negedge CLK);
    MemRdata = $urandom;
    #1;
    model_check();
    cyc++;
  endtask

  task automatic finish_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IReq = 0; IAddr = '0; DReq = 0; DWe = 0; DFunct3 = 3'b000; DAddr = '0; DWdata = '0;
  endtask

  task automatic all_outputs_zero(input string tag);
    chk({tag, "_IGnt"},   32'(IGnt),   32'h0);
    chk({tag, "_DGnt"},   32'(DGnt),   32'h0);
    chk({tag, "_IValid"}, 32'(IValid), 32'h0);
    chk({tag, "_DValid"}, 32'(DValid), 32'h0);
    chk({tag, "_Errs"},   32'({IErr, DErr}), 32'h0);
    chk({tag, "_MemCtl"}, 32'({MemEn, MemWe, MemFunct3}), 32'h0);
    chk({tag, "_MemAddr"}, MemAddr, 32'h0);
    chk({tag, "_MemWdata"}, MemWdata, 32'h0);
    chk({tag, "_Rdata"},  IRdata | DRdata, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ireq; logic [31:0] iaddr;
    bit dreq; bit dwe; logic [2:0] f3; logic [31:0] daddr; logic [31:0] dwdata;
    bit e_ignt; bit e_dgnt; bit e_memen; bit e_memwe; logic [2:0] e_f3;
    logic [31:0] e_addr; logic [31:0] e_wdata;
    bit e_dside; bit e_err; bit e_rd;
  } vec_t;

  function automatic vec_t mkv(
    input bit ireq, input logic [31:0] iaddr,
    input bit dreq, input bit dwe, input logic [2:0] f3, input logic [31:0] daddr,
    input logic [31:0] dwdata,
    input bit e_ignt, input bit e_dgnt, input bit e_memen, input bit e_memwe,
    input logic [2:0] e_f3, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input bit e_dside, input bit e_err, input bit e_rd);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.f3 = f3;
    v.daddr = daddr; v.dwdata = dwdata; v.e_ignt = e_ignt; v.e_dgnt = e_dgnt;
    v.e_memen = e_memen; v.e_memwe = e_memwe; v.e_f3 = e_f3; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_dside = e_dside; v.e_err = e_err; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    logic [2:0] ld_f3[5];
    logic [2:0] st_f3[3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};

    //          ireq iaddr   dreq we f3      daddr    dwdata     ignt dgnt en we ef3     eaddr    ewdata    dside err rd
    tbl[0] = mkv(1, 32'h10,  0, 0, 3'b000, 32'h0,   32'h0,     1, 0, 1, 0, 3'b010, 32'h10,  32'h0,    0, 0, 1);
    tbl[1] = mkv(0, 32'h0,   1, 1, 3'b010, 32'h22,  32'h1234,  0, 1, 0, 0, 3'b000, 32'h0,   32'h0,    1, 1, 0);
    tbl[2] = mkv(0, 32'h0,   1, 1, 3'b001, 32'h6,   32'hA5A5,  0, 1, 1, 1, 3'b001, 32'h6,   32'hA5A5, 1, 0, 0);
    tbl[3] = mkv(0, 32'h0,   1, 0, 3'b010, 32'h100, 32'hFFFF,  0, 1, 1, 0, 3'b010, 32'h100, 32'h0,    1, 0, 1);
    tbl[4] = mkv(0, 32'h0,   1, 0, 3'b100, 32'h103, 32'h0,     0, 1, 1, 0, 3'b100, 32'h103, 32'h0,    1, 0, 1);
    tbl[5] = mkv(0, 32'h0,   1, 0, 3'b101, 32'h103, 32'h0,     0, 1, 0, 0, 3'b000, 32'h0,   32'h0,    1, 1, 0);
    tbl[6] = mkv(1, 32'h12,  0, 0, 3'b000, 32'h0,   32'h0,     1, 0, 0, 0, 3'b000, 32'h0,   32'h0,    0, 1, 0);
    tbl[7] = mkv(1, 32'h40,  1, 0, 3'b010, 32'h80,  32'h0,     0, 1, 1, 0, 3'b010, 32'h80,  32'h0,    1, 0, 1);
    tbl[8] = mkv(0, 32'h0,   1, 0, 3'b001, 32'h2,   32'h0,     0, 1, 1, 0, 3'b001, 32'h2,   32'h0,    1, 0, 1);

    // ---------- reset state, requests asserted to prove gating ----------
    idle();
    MemRdata = 32'hDEAD_BEEF;
    Reset_n  = 1'b0;
    IReq = 1; IAddr = 32'h10; DReq = 1; DAddr = 32'h20; DFunct3 = 3'b010;
    repeat (3) @(posedge CLK);
    #1;
    all_outputs_zero("reset");
    idle();
    @(negedge CLK);
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();

    // ---------- table vectors: grant cycle then idle response cycle ----------
    for (int i = 0; i < 9; i++) begin
      IReq = tbl[i].ireq; IAddr = tbl[i].iaddr;
      DReq = tbl[i].dreq; DWe = tbl[i].dwe; DFunct3 = tbl[i].f3;
      DAddr = tbl[i].daddr; DWdata = tbl[i].dwdata;
      sample_cycle();
      chk($sformatf("tbl%0d_IGnt", i), 32'(IGnt), 32'(tbl[i].e_ignt));
      chk($sformatf("tbl%0d_DGnt", i), 32'(DGnt), 32'(tbl[i].e_dgnt));
      chk($sformatf("tbl%0d_MemEn", i), 32'(MemEn), 32'(tbl[i].e_memen));
      chk($sformatf("tbl%0d_MemWe", i), 32'(MemWe), 32'(tbl[i].e_memwe));
      chk($sformatf("tbl%0d_MemFunct3", i), 32'(MemFunct3), 32'(tbl[i].e_f3));
      chk($sformatf("tbl%0d_MemAddr", i), MemAddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_MemWdata", i), MemWdata, tbl[i].e_wdata);
      finish_cycle();
      idle();
      sample_cycle();
      chk($sformatf("tbl%0d_IValid", i), 32'(IValid), 32'(!tbl[i].e_dside));
      chk($sformatf("tbl%0d_DValid", i), 32'(DValid), 32'(tbl[i].e_dside));
      chk($sformatf("tbl%0d_Err", i), 32'(tbl[i].e_dside ? DErr : IErr), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_Rdata", i), tbl[i].e_dside ? DRdata : IRdata,
          tbl[i].e_rd ? MemRdata : 32'h0);
      finish_cycle();
    end

    // ---------- alternating single-cycle fetch / load, no bubbles ----------
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k % 2 == 0) begin IReq = 1; IAddr = 32'(k * 4); end
      else begin DReq = 1; DFunct3 = 3'b010; DAddr = 32'(32'h200 + k * 4); end
      sample_cycle();
      chk("alt_grant", 32'(IGnt | DGnt), 32'h1);
      if (k > 0) begin
        chk("alt_IValid", 32'(IValid), 32'((k - 1) % 2 == 0));
        chk("alt_DValid", 32'(DValid), 32'((k - 1) % 2 == 1));
      end
      finish_cycle();
    end

    // ---------- reset asserted the cycle after a data grant ----------
    idle();
    DReq = 1; DFunct3 = 3'b010; DAddr = 32'h20; IReq = 1; IAddr = 32'h44;
    m_starve = 0;  // preceding alternation cleared it with a fetch grant
    sample_cycle();
    chk("rst_pre_DGnt", 32'(DGnt), 32'h1);
    @(posedge CLK);
    #1;
    Reset_n = 1'b0;
    #1;
    all_outputs_zero("rst_async");
    @(posedge CLK);
    #1;
    all_outputs_zero("rst_held");
    idle();
    @(negedge CLK);
    Reset_n = 1'b1;
    #1;
    chk("rst_rel_DValid", 32'(DValid), 32'h0);
    @(posedge CLK);
    #1;
    model_reset();
    sample_cycle();
    chk("rst_after_DValid", 32'(DValid), 32'h0);
    finish_cycle();

    // ---------- starvation: both held 6 cycles -> D D D D I D ----------
    IReq = 1; IAddr = 32'h80; DReq = 1; DWe = 0; DFunct3 = 3'b010; DAddr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      sample_cycle();
      chk($sformatf("starve%0d_IGnt", k), 32'(IGnt), 32'(k == 4));
      chk($sformatf("starve%0d_DGnt", k), 32'(DGnt), 32'(k != 4));
      finish_cycle();
    end
    idle();
    sample_cycle();
    finish_cycle();

    // ---------- randomized run against the model ----------
    for (int n = 0; n < 400; n++) begin
      if (!(IReq && !last_ignt)) begin
        IReq  = ($urandom_range(0, 3) != 0);
        IAddr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 5) == 0) IAddr[1:0] = 2'($urandom_range(1, 3));
      end
      if (!(DReq && !last_dgnt)) begin
        DReq    = ($urandom_range(0, 3) != 0);
        DWe     = $urandom_range(0, 1);
        DFunct3 = DWe ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
        DAddr   = 32'($urandom_range(0, 1023));
        DWdata  = $urandom;
      end
      sample_cycle();
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
